chaout_arbiter: RTL and testbench
=================================

// Module: chaout_arbiter
// PURPOSE
//  Round-robin scheduler that shares one chaout invert/pass datapath between NUM_REQ requesters.
//  Accepts one (data, invert-mode) job per grant, drives chaout in/sel, and registers its result.
//  Presents the result downstream with a valid/ready handshake and the winning requester id.
//  Sits between the input-pin request logic and the output mux of the invert test design.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  WIDTH    5   datapath width; must match chaout
//  TIMEOUT  15  HOLD cycles before a result is dropped (only with CHAOUT_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst          in   1                  synchronous, active-high reset
//  req_valid    in   NUM_REQ            per-requester job valid
//  req_ready    out  NUM_REQ            per-requester accept; one-hot or zero
//  req_data     in   NUM_REQ*WIDTH      job data; requester i at [i*WIDTH +: WIDTH]
//  req_inv      in   NUM_REQ            job mode: 1 = invert, 0 = pass
//  dp_in        out  WIDTH              to chaout .in
//  dp_sel       out  1                  to chaout .sel (1 = out = ~in, 0 = out = in)
//  dp_out       in   WIDTH              from chaout .out
//  out_valid    out  1                  result valid
//  out_ready    in   1                  downstream accept
//  out_data     out  WIDTH              registered chaout result
//  out_id       out  $clog2(NUM_REQ)    index of the requester that owns out_data
//  busy         out  1                  1 whenever state != IDLE
//  timeout_err  out  1                  1-cycle pulse when a result is dropped; tied 0 without macro
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, dp_in=0, dp_sel=0, out_valid=0, out_data=0, out_id=0, busy=0, timeout_err=0.
//  FSM: IDLE -> SAMPLE -> HOLD -> IDLE.
//   IDLE: grant = first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
//    req_ready[grant] = 1 combinationally.
//    On accept, register req_data and req_inv into dp_in/dp_sel, set out_id = grant, go to SAMPLE.
//    With no valid requester, stay in IDLE with req_ready = 0.
//   SAMPLE: out_data <= dp_out, out_valid <= 1, go to HOLD.
//   HOLD: out_valid, out_data and out_id stay stable; req_ready = 0.
//    On out_valid & out_ready: out_valid <= 0, rr_ptr <= out_id+1 (wraps to 0 after NUM_REQ-1), go to IDLE.
//  Latency: accept at cycle T, out_valid high from T+2. Minimum 3 cycles per job.
//  req_ready is 0 in every state except IDLE. req_valid may drop while not granted (no accept occurs).
//  dp_in and dp_sel hold their value between jobs.
//  Reset mid-operation discards the in-flight job: no out_valid, and rr_ptr returns to 0.
// CONFIGURATION
//  CHAOUT_ARB_TIMEOUT_EN defined:
//   HOLD counts cycles with out_ready = 0.
//   At count == TIMEOUT, drop the result (out_valid <= 0), pulse timeout_err, advance rr_ptr, go to IDLE.
//   The counter clears on entry to HOLD.
//  Not defined: HOLD waits indefinitely; timeout_err = 0 constant; no counter logic.
// STRUCTURE
//  Package chaout_arb_pkg: state typedef (IDLE/SAMPLE/HOLD) and default WIDTH constant.
//  Sub-module chaout_rr_pick: combinational round-robin one-hot picker (req_valid, rr_ptr -> grant index/onehot).
//  chaout itself is instantiated by the parent, not inside this block.
// TESTING (NUM_REQ=4, WIDTH=5, TIMEOUT=15; bench instantiates chaout)
//  Single job: req 2 sends 5'b00110 with inv=1 -> req_ready[2] at T; out_valid at T+2; out_data=5'b11001, out_id=2.
//  Pass mode: req 0 sends 5'b10011 with inv=0 -> out_data=5'b10011, out_id=0.
//  Fairness: all req_valid=1 from reset, out_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
//  Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data/out_id stable and req_ready=0 for those cycles;
//   accept on the 11th cycle.
//  Reset in SAMPLE: assert rst for 1 cycle -> next cycle out_valid=0, busy=0, rr_ptr=0;
//   the next grant goes to the lowest valid index.
//  Timeout (macro on): out_ready=0 -> out_valid falls after 15 HOLD cycles, timeout_err high exactly 1 cycle.
//   Macro off: out_valid held for 100+ cycles and timeout_err=0.

Source files
------------

// File: rtl/chaout_arb_pkg.sv
// Shared types and constants for the chaout round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package chaout_arb_pkg;

  // Default datapath width; has to agree with the chaout instance it feeds.
  localparam int CHAOUT_DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/chaout_arbiter_if.sv
// Request and result handshake bundle of the chaout arbiter.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready per requester, out_valid/out_ready downstream.
// Ports: master = requesters plus downstream sink, slave = arbiter.
interface chaout_arbiter_if
  import chaout_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = CHAOUT_DEFAULT_WIDTH
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_inv;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;

  modport master (
    output req_valid, req_data, req_inv, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, req_inv, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/chaout.sv
// Invert/pass datapath shared by the arbiter's requesters.
// Latency: combinational.
// Backpressure: none.
// Ports: in (data), sel (1 = invert), out (result).
module chaout #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? ~in : in;
endmodule

// File: rtl/chaout_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; grant_any = 0 when no requester is valid.
// Ports: req_valid, rr_ptr in; grant_idx, grant_oh, grant_any out.
module chaout_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     grant_idx,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic               grant_any
);
  always_comb begin
    int j;
    j         = 0;
    grant_idx = '0;
    grant_any = |req_valid;
    // Walk from the farthest offset down so the nearest valid one wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) grant_idx = IDW'(j);
    end
    grant_oh = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/chaout_arbiter.sv
// Round-robin scheduler sharing one chaout invert/pass datapath between NUM_REQ requesters.
// Latency: accept at T, out_valid from T+2; at least 3 cycles per job.
// Backpressure: result held in HOLD until out_ready; req_ready is 0 outside IDLE.
// Ports: clk, rst (sync, active high), bus (slave handshakes), dp_in/dp_sel/dp_out to chaout,
//        busy, timeout_err. Optional macro CHAOUT_ARB_TIMEOUT_EN drops a result after TIMEOUT
//        stalled HOLD cycles; without it timeout_err is tied 0.
module chaout_arbiter
  import chaout_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = CHAOUT_DEFAULT_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  chaout_arbiter_if.slave  bus,
  output logic [WIDTH-1:0] dp_in,
  output logic             dp_sel,
  input  logic [WIDTH-1:0] dp_out,
  output logic             busy,
  output logic             timeout_err
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   dp_in_q, dp_in_d;
  logic               dp_sel_q, dp_sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]     out_id_q, out_id_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [NUM_REQ-1:0] req_ready;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any;
  logic [IDW-1:0]     rr_next;

`ifdef CHAOUT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  chaout_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh),
    .grant_any (grant_any)
  );

  // Fairness pointer moves past the owner of the finished (or dropped) job.
  assign rr_next = (out_id_q == IDW'(NUM_REQ - 1)) ? '0 : out_id_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    dp_in_d       = dp_in_q;
    dp_sel_d      = dp_sel_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_id_d      = out_id_q;
    timeout_err_d = 1'b0;
    req_ready     = '0;
`ifdef CHAOUT_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = grant_oh;
        if (grant_any) begin
          dp_in_d  = bus.req_data[grant_idx*WIDTH +: WIDTH];
          dp_sel_d = bus.req_inv[grant_idx];
          out_id_d = grant_idx;
          state_d  = SAMPLE;
        end
      end
      SAMPLE: begin
        out_data_d  = dp_out;
        out_valid_d = 1'b1;
        state_d     = HOLD;
`ifdef CHAOUT_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = rr_next;
          state_d     = IDLE;
        end
`ifdef CHAOUT_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            out_valid_d   = 1'b0;
            timeout_err_d = 1'b1;
            rr_ptr_d      = rr_next;
            state_d       = IDLE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      dp_in_q       <= '0;
      dp_sel_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_id_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef CHAOUT_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      dp_in_q       <= dp_in_d;
      dp_sel_q      <= dp_sel_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_id_q      <= out_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
`ifdef CHAOUT_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign dp_in         = dp_in_q;
  assign dp_sel        = dp_sel_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_chaout_arbiter.sv
// Directed bench for chaout_arbiter with the real chaout datapath attached.
// Latency: n/a.
// Backpressure: drives out_ready low for stall and hold scenarios.
module tb_chaout_arbiter;
  logic       clk;
  logic       rst;
  logic [4:0] dp_in;
  logic       dp_sel;
  logic [4:0] dp_out;
  logic       busy;
  logic       timeout_err;
  int         checks;
  int         errors;

  chaout_arbiter_if #(.NUM_REQ(4), .WIDTH(5)) bus ();

  chaout_arbiter #(.NUM_REQ(4), .WIDTH(5), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dp_in       (dp_in),
    .dp_sel      (dp_sel),
    .dp_out      (dp_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  chaout #(.WIDTH(5)) u_chaout (.in(dp_in), .sel(dp_sel), .out(dp_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [19:0] dat;
    logic [3:0]  inv;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [4:0]  e_od;
    logic [1:0]  e_id;
    logic        e_busy;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] vld, input logic [19:0] dat,
                       input logic [3:0] inv, input logic ordy);
    bus.req_valid = vld;
    bus.req_data  = dat;
    bus.req_inv   = inv;
    bus.out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [19:0] dat, input logic [3:0] inv,
                              input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                              input logic [4:0] e_od, input logic [1:0] e_id, input logic e_busy);
    vec_t v;
    v.vld = vld; v.dat = dat; v.inv = inv; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_id = e_id; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    logic [19:0] all_dat;
    logic [19:0] fair_dat;
    logic [3:0]  fair_inv;
    logic [4:0]  exp_d;
    int          g;
    int          n_valid;
    int          n_te;
    checks = 0;
    errors = 0;
    all_dat  = {5'd1, 5'd2, 5'd3, 5'd4};
    fair_dat = {5'b00011, 5'b00100, 5'b01000, 5'b10000};
    fair_inv = 4'b1010;

    // Single invert job from req 2, then a pass job from req 0 with a stall.
    tv[0] = mk(4'b0100, {5'd0, 5'b00110, 10'd0}, 4'b0100, 1'b1, 4'b0100, 1'b0, 5'b00000, 2'd0, 1'b0);
    tv[1] = mk(4'b0000, 20'd0,                   4'b0000, 1'b1, 4'b0000, 1'b0, 5'b00000, 2'd2, 1'b1);
    tv[2] = mk(4'b0000, 20'd0,                   4'b0000, 1'b1, 4'b0000, 1'b1, 5'b11001, 2'd2, 1'b1);
    tv[3] = mk(4'b0001, {15'd0, 5'b10011},       4'b0000, 1'b1, 4'b0001, 1'b0, 5'b11001, 2'd2, 1'b0);
    tv[4] = mk(4'b0000, 20'd0,                   4'b0000, 1'b1, 4'b0000, 1'b0, 5'b11001, 2'd0, 1'b1);
    tv[5] = mk(4'b0000, 20'd0,                   4'b0000, 1'b0, 4'b0000, 1'b1, 5'b10011, 2'd0, 1'b1);
    tv[6] = mk(4'b1111, all_dat,                 4'b0000, 1'b1, 4'b0000, 1'b1, 5'b10011, 2'd0, 1'b1);
    tv[7] = mk(4'b1111, all_dat,                 4'b0000, 1'b0, 4'b0010, 1'b0, 5'b10011, 2'd0, 1'b0);

    // Reset state.
    rst = 1'b1;
    drive(4'b0000, 20'd0, 4'b0000, 1'b0);
    cyc();
    cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_id",    32'(bus.out_id),    32'h0);
    chk("rst_busy",      32'(busy),          32'h0);
    chk("rst_timeout",   32'(timeout_err),   32'h0);
    chk("rst_dp_in",     32'(dp_in),         32'h0);
    chk("rst_dp_sel",    32'(dp_sel),        32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].vld, tv[i].dat, tv[i].inv, tv[i].ordy);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(tv[i].e_od));
      chk($sformatf("v%0d_out_id", i),    32'(bus.out_id),    32'(tv[i].e_id));
      chk($sformatf("v%0d_busy", i),      32'(busy),          32'(tv[i].e_busy));
      chk($sformatf("v%0d_timeout", i),   32'(timeout_err),   32'h0);
      cyc();
    end

    // Backpressure: req 1 (data 3, pass) now in SAMPLE; stall 10 HOLD cycles.
    drive(4'b1111, all_dat, 4'b0000, 1'b0);
    #1;
    chk("bp_sample_busy", 32'(busy), 32'h1);
    cyc();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp%0d_out_data", c),  32'(bus.out_data),  32'h3);
      chk($sformatf("bp%0d_out_id", c),    32'(bus.out_id),    32'h1);
      chk($sformatf("bp%0d_req_ready", c), 32'(bus.req_ready), 32'h0);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_accept_valid", 32'(bus.out_valid), 32'h1);
    cyc();
    chk("bp_after_valid", 32'(bus.out_valid), 32'h0);
    chk("bp_next_grant",  32'(bus.req_ready), 32'b0100);

    // Reset while in SAMPLE: accept req 2 (rr_ptr stays 2), then reset.
    cyc();
    drive(4'b0000, 20'd0, 4'b0000, 1'b1);
    rst = 1'b1;
    #1;
    chk("rs_in_sample_busy", 32'(busy), 32'h1);
    cyc();
    rst = 1'b0;
    drive(4'b1010, all_dat, 4'b0000, 1'b1);
    #1;
    chk("rs_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rs_busy",      32'(busy),          32'h0);
    chk("rs_grant_low", 32'(bus.req_ready), 32'b0010);
    cyc();
    drive(4'b0000, 20'd0, 4'b0000, 1'b1);
    cyc();
    chk("rs_job_valid", 32'(bus.out_valid), 32'h1);
    chk("rs_job_data",  32'(bus.out_data),  32'h3);
    chk("rs_job_id",    32'(bus.out_id),    32'h1);
    cyc();

    // Fairness from reset: all requesters valid, downstream always ready.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(4'b1111, fair_dat, fair_inv, 1'b1);
    for (int c = 0; c < 15; c++) begin
      g = (c / 3) % 4;
      #1;
      if (c % 3 == 0) chk($sformatf("fair%0d_req_ready", c), 32'(bus.req_ready), 32'(4'b0001 << g));
      else            chk($sformatf("fair%0d_req_ready", c), 32'(bus.req_ready), 32'h0);
      if (c % 3 == 2) begin
        exp_d = fair_dat[g*5 +: 5] ^ {5{fair_inv[g]}};
        chk($sformatf("fair%0d_out_valid", c), 32'(bus.out_valid), 32'h1);
        chk($sformatf("fair%0d_out_id", c),    32'(bus.out_id),    32'(g));
        chk($sformatf("fair%0d_out_data", c),  32'(bus.out_data),  32'(exp_d));
      end
      cyc();
    end

    // Long stall in HOLD: req 0, data 0x0A inverted -> 0x15.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(4'b0001, {15'd0, 5'h0A}, 4'b0001, 1'b0);
    cyc();
    drive(4'b0000, 20'd0, 4'b0000, 1'b0);
    cyc();
    n_valid = 0;
    n_te    = 0;
    for (int c = 0; c < 110; c++) begin
      if (bus.out_valid === 1'b1 && bus.out_data === 5'h15) n_valid++;
      if (timeout_err === 1'b1) n_te++;
      cyc();
    end
`ifdef CHAOUT_ARB_TIMEOUT_EN
    chk("to_valid_cycles", 32'(n_valid), 32'd15);
    chk("to_err_pulses",   32'(n_te),    32'd1);
    chk("to_busy_after",   32'(busy),    32'h0);
`else
    chk("hold_valid_cycles", 32'(n_valid), 32'd110);
    chk("hold_err_pulses",   32'(n_te),    32'd0);
    chk("hold_busy",         32'(busy),    32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
